// File: rtl/decode_cycle.sv
// Decode stage: instruction decode, 32x24 register file with write-first bypass,
// immediate sign-extension and the ID/EX pipeline register.
module decode_cycle (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWriteW,
   input  logic [4:0]  RDW,
   input  logic [23:0] ResultW,
   input  logic [33:0] InstrD,
   input  logic [23:0] PCD,
   input  logic [23:0] PCPlus4D,
   output logic        RegWriteE,
   output logic        ALUSrcE,
   output logic        MemWriteE,
   output logic        ResultSrcE,
   output logic        BranchE,
   output logic [2:0]  ALUControlE,
   output logic [23:0] RD1_E,
   output logic [23:0] RD2_E,
   output logic [23:0] Imm_Ext_E,
   output logic [4:0]  RS1_E,
   output logic [4:0]  RS2_E,
   output logic [4:0]  RD_E,
   output logic [23:0] PCE,
   output logic [23:0] PCPlus4E
);

   localparam logic [3:0] OP_NOP   = 4'b0000;
   localparam logic [3:0] OP_LOAD  = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SUB   = 4'b0011;
   localparam logic [3:0] OP_AND   = 4'b0100;
   localparam logic [3:0] OP_OR    = 4'b0101;
   localparam logic [3:0] OP_BEQ   = 4'b0110;
   localparam logic [3:0] OP_STORE = 4'b0111;
   localparam logic [3:0] OP_XOR   = 4'b1000;
   localparam logic [3:0] OP_ADDI  = 4'b1001;
   localparam logic [3:0] OP_SLT   = 4'b1010;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   logic [3:0]  w_op;
   logic [4:0]  w_rd, w_rs1, w_rs2;
   logic        w_reg_write, w_alu_src, w_mem_write, w_result_src, w_branch, w_imm_sb;
   logic [2:0]  w_alu_ctrl;
   logic [19:0] w_imm20;
   logic [23:0] w_imm_ext, w_rd1, w_rd2;
   logic [31:0][23:0] r_regs;

   assign w_op  = InstrD[33:30];
   assign w_rd  = InstrD[29:25];
   assign w_rs1 = InstrD[24:20];
   assign w_rs2 = InstrD[19:15];

   always_comb begin
      w_reg_write  = 1'b0;
      w_alu_src    = 1'b0;
      w_mem_write  = 1'b0;
      w_result_src = 1'b0;
      w_branch     = 1'b0;
      w_alu_ctrl   = ALU_ADD;
      w_imm_sb     = 1'b0;
      case (w_op)
         OP_LOAD:  begin w_reg_write = 1'b1; w_alu_src = 1'b1; w_result_src = 1'b1; end
         OP_ADD:   w_reg_write = 1'b1;
         OP_SUB:   begin w_reg_write = 1'b1; w_alu_ctrl = ALU_SUB; end
         OP_AND:   begin w_reg_write = 1'b1; w_alu_ctrl = ALU_AND; end
         OP_OR:    begin w_reg_write = 1'b1; w_alu_ctrl = ALU_OR;  end
         OP_BEQ:   begin w_branch = 1'b1; w_alu_ctrl = ALU_SUB; w_imm_sb = 1'b1; end
         OP_STORE: begin w_mem_write = 1'b1; w_alu_src = 1'b1; w_imm_sb = 1'b1; end
         OP_XOR:   begin w_reg_write = 1'b1; w_alu_ctrl = ALU_XOR; end
         OP_ADDI:  begin w_reg_write = 1'b1; w_alu_src = 1'b1; end
         OP_SLT:   begin w_reg_write = 1'b1; w_alu_ctrl = ALU_SLT; end
         default:  ;  // NOP and reserved opcodes 1011-1111
      endcase
   end

   // S/B-form splits the immediate around rs1/rs2: high bits live in the rd slot.
   assign w_imm20   = w_imm_sb ? {InstrD[29:25], InstrD[14:0]} : InstrD[19:0];
   assign w_imm_ext = {{4{w_imm20[19]}}, w_imm20};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_regs <= '0;
      else if (RegWriteW && (RDW != 5'd0))
         r_regs[RDW] <= ResultW;
   end

   // Write-first bypass so a same-cycle writeback is visible to this read.
   always_comb begin
      w_rd1 = r_regs[w_rs1];
      w_rd2 = r_regs[w_rs2];
      if (RegWriteW && (RDW == w_rs1)) w_rd1 = ResultW;
      if (RegWriteW && (RDW == w_rs2)) w_rd2 = ResultW;
      if (w_rs1 == 5'd0) w_rd1 = '0;
      if (w_rs2 == 5'd0) w_rd2 = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         RegWriteE   <= 1'b0;
         ALUSrcE     <= 1'b0;
         MemWriteE   <= 1'b0;
         ResultSrcE  <= 1'b0;
         BranchE     <= 1'b0;
         ALUControlE <= '0;
         RD1_E       <= '0;
         RD2_E       <= '0;
         Imm_Ext_E   <= '0;
         RS1_E       <= '0;
         RS2_E       <= '0;
         RD_E        <= '0;
         PCE         <= '0;
         PCPlus4E    <= '0;
      end else begin
         RegWriteE   <= w_reg_write;
         ALUSrcE     <= w_alu_src;
         MemWriteE   <= w_mem_write;
         ResultSrcE  <= w_result_src;
         BranchE     <= w_branch;
         ALUControlE <= w_alu_ctrl;
         RD1_E       <= w_rd1;
         RD2_E       <= w_rd2;
         Imm_Ext_E   <= w_imm_ext;
         RS1_E       <= w_rs1;
         RS2_E       <= w_rs2;
         RD_E        <= w_rd;
         PCE         <= PCD;
         PCPlus4E    <= PCPlus4D;
      end
   end

endmodule

// File: tb/tb_decode_cycle.sv
// Scoreboard bench for decode_cycle: expectations from a bench-side register
// file and opcode table are queued at drive time and checked after the edge.
module tb_decode_cycle;

   logic        clk, rst, RegWriteW;
   logic [4:0]  RDW;
   logic [23:0] ResultW, PCD, PCPlus4D;
   logic [33:0] InstrD;
   logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
   logic [2:0]  ALUControlE;
   logic [23:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
   logic [4:0]  RS1_E, RS2_E, RD_E;

   decode_cycle dut (
      .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
      .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
      .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
      .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
      .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E), .PCE(PCE), .PCPlus4E(PCPlus4E)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rw, as, mw, rs, br;
      logic [2:0]  alu;
      logic [23:0] rd1, rd2, imm, pc, pc4;
      logic [4:0]  s1, s2, d;
   } exp_t;

   exp_t        q[$];
   logic [23:0] m_regs [32];
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [33:0] ins, input logic wen,
                                  input logic [4:0] wd, input logic [23:0] wdat,
                                  input logic [23:0] pc, input logic [23:0] pc4);
      exp_t e;
      logic [19:0] i20;
      logic sb;
      e = '{default: '0};
      sb = 1'b0;
      case (ins[33:30])
         4'b0001: begin e.rw = 1; e.as = 1; e.rs = 1; end
         4'b0010: e.rw = 1;
         4'b0011: begin e.rw = 1; e.alu = 3'b001; end
         4'b0100: begin e.rw = 1; e.alu = 3'b010; end
         4'b0101: begin e.rw = 1; e.alu = 3'b011; end
         4'b0110: begin e.br = 1; e.alu = 3'b001; sb = 1; end
         4'b0111: begin e.mw = 1; e.as = 1; sb = 1; end
         4'b1000: begin e.rw = 1; e.alu = 3'b100; end
         4'b1001: begin e.rw = 1; e.as = 1; end
         4'b1010: begin e.rw = 1; e.alu = 3'b101; end
         default: ;
      endcase
      i20   = sb ? {ins[29:25], ins[14:0]} : ins[19:0];
      e.imm = {{4{i20[19]}}, i20};
      e.d   = ins[29:25];
      e.s1  = ins[24:20];
      e.s2  = ins[19:15];
      e.rd1 = (e.s1 == 0) ? 24'h0 : (wen && wd == e.s1) ? wdat : m_regs[e.s1];
      e.rd2 = (e.s2 == 0) ? 24'h0 : (wen && wd == e.s2) ? wdat : m_regs[e.s2];
      e.pc  = pc;
      e.pc4 = pc4;
      return e;
   endfunction

   task automatic check_pop();
      exp_t e;
      if (q.size() == 0) begin
         chk("queue_empty", 24'h1, 24'h0);
         return;
      end
      e = q.pop_front();
      chk("RegWriteE", {23'b0, RegWriteE}, {23'b0, e.rw});
      chk("ALUSrcE", {23'b0, ALUSrcE}, {23'b0, e.as});
      chk("MemWriteE", {23'b0, MemWriteE}, {23'b0, e.mw});
      chk("ResultSrcE", {23'b0, ResultSrcE}, {23'b0, e.rs});
      chk("BranchE", {23'b0, BranchE}, {23'b0, e.br});
      chk("ALUControlE", {21'b0, ALUControlE}, {21'b0, e.alu});
      chk("RD1_E", RD1_E, e.rd1);
      chk("RD2_E", RD2_E, e.rd2);
      chk("Imm_Ext_E", Imm_Ext_E, e.imm);
      chk("RS1_E", {19'b0, RS1_E}, {19'b0, e.s1});
      chk("RS2_E", {19'b0, RS2_E}, {19'b0, e.s2});
      chk("RD_E", {19'b0, RD_E}, {19'b0, e.d});
      chk("PCE", PCE, e.pc);
      chk("PCPlus4E", PCPlus4E, e.pc4);
   endtask

   // Called just after a negedge: drive, queue expectation, clock, check at next negedge.
   task automatic step(input logic [33:0] ins, input logic wen, input logic [4:0] wd,
                       input logic [23:0] wdat, input logic [23:0] pc);
      InstrD = ins; RegWriteW = wen; RDW = wd; ResultW = wdat;
      PCD = pc; PCPlus4D = pc + 24'd4;
      q.push_back(model(ins, wen, wd, wdat, pc, pc + 24'd4));
      @(posedge clk);
      if (wen && wd != 0) m_regs[wd] = wdat;
      @(negedge clk);
      check_pop();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctl"}, {19'b0, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE}, 24'h0);
      chk({tag, "_alu"}, {21'b0, ALUControlE}, 24'h0);
      chk({tag, "_rd1"}, RD1_E, 24'h0);
      chk({tag, "_rd2"}, RD2_E, 24'h0);
      chk({tag, "_imm"}, Imm_Ext_E, 24'h0);
      chk({tag, "_idx"}, {9'b0, RS1_E, RS2_E, RD_E}, 24'h0);
      chk({tag, "_pc"}, PCE, 24'h0);
      chk({tag, "_pc4"}, PCPlus4E, 24'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] t;
      rst = 1'b0; RegWriteW = 0; RDW = 0; ResultW = 0;
      InstrD = 0; PCD = 0; PCPlus4D = 0;
      for (int i = 0; i < 32; i++) m_regs[i] = 24'h0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset_init");
      rst = 1'b1;

      // ADD with bypass of x1
      step(34'b0010_00010_00001_00001_000000000000000, 1'b1, 5'd1, 24'h000001, 24'h000004);
      // ADDI, immediate 0xFF
      step(34'b1001_00010_00010_00000000000011111111, 1'b0, 5'd0, 24'h0, 24'h000010);
      // LOAD with negative immediate
      step({4'b0001, 5'd3, 5'd1, 20'hFFFFF}, 1'b1, 5'd2, 24'h123456, 24'h000020);
      // BEQ: rd slot 00110, low immediate 6
      step({4'b0110, 5'b00110, 5'd1, 5'd2, 15'd6}, 1'b0, 5'd0, 24'h0, 24'h000030);
      // STORE with negative S-form immediate
      step({4'b0111, 5'b10000, 5'd2, 5'd1, 15'd9}, 1'b0, 5'd0, 24'h0, 24'h000040);
      // x0 protection: write to x0 ignored, bypass suppressed
      step({4'b0010, 5'd4, 5'd0, 5'd0, 15'd0}, 1'b1, 5'd0, 24'hABCDEF, 24'h000050);
      step({4'b0010, 5'd4, 5'd0, 5'd1, 15'd0}, 1'b0, 5'd0, 24'h0, 24'h000054);
      // Reserved opcode decodes as NOP but fields still pass through
      step({4'b1101, 5'd7, 5'd1, 5'd2, 15'h7FFF}, 1'b1, 5'd9, 24'h00BEEF, 24'h000058);

      for (int i = 0; i < 150; i++) begin
         t = {$urandom(), $urandom()};
         step(t[33:0], 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
              24'($urandom()), 24'($urandom()));
      end

      // Mid-run asynchronous reset, held across an edge with a writeback pending
      #2 rst = 1'b0;
      #1 chk_all_zero("reset_async");
      RegWriteW = 1'b1; RDW = 5'd5; ResultW = 24'h55AA55;
      @(negedge clk);
      chk_all_zero("reset_hold");
      for (int i = 0; i < 32; i++) m_regs[i] = 24'h0;
      rst = 1'b1;
      step({4'b0010, 5'd3, 5'd1, 5'd2, 15'd0}, 1'b0, 5'd0, 24'h0, 24'h000100);
      step({4'b0011, 5'd3, 5'd5, 5'd31, 15'd0}, 1'b0, 5'd0, 24'h0, 24'h000104);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
